time_upd_sched: RTL
===================

# time_upd_sched

Update scheduler for the countdown timer's time registers. Sits between the `Ctl` controller and the minutes/seconds counter datapath. Owns that datapath's single update port and shares it among three requesters: the 1-second run tick, manual increment and manual decrement (with auto-repeat on held buttons). Also generates the `complete` level back to `Ctl` when a run tick finds the time already at zero.

## Interface
- `TICK_DIV`, 100_000_000: clock cycles per run tick (1 s at 100 MHz).
- `REPEAT_DELAY`, 50_000_000: cycles a button must stay held after its first pulse before auto-repeat starts.
- `REPEAT_PERIOD`, 10_000_000: cycles between auto-repeat pulses.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `init_regs`  in  1  from `Ctl`: reload/clear request.
- `count_enabled`  in  1  from `Ctl`: running.
- `inc`  in  1  from `Ctl`: up button, level.
- `dec`  in  1  from `Ctl`: down button, level.
- `min`  in  1  from `Ctl`: selected field, 1 = minutes, 0 = seconds.
- `zero`  in  1  from datapath: all time digits are 0.
- `upd_valid`  out  1  one-cycle strobe; datapath applies `upd_op` on this cycle.
- `upd_op`  out  2  00 none, 01 inc field, 10 dec field, 11 tick (decrement total time by 1 s, with borrow).
- `upd_field`  out  1  field for inc/dec; 0 during tick.
- `complete`  out  1  sticky done level to `Ctl`.

## Operation
- All outputs are registered.
- Reset values: `upd_valid`=0, `upd_op`=00, `upd_field`=0, `complete`=0. The prescaler and both repeat FSMs are cleared.
- **Prescaler**
  - Counts 0..TICK_DIV-1 while `count_enabled`=1, then wraps.
  - Holds its value while `count_enabled`=0 (pause keeps the fractional second).
  - Cleared by `init_regs`.
- **Tick request**: raised on the prescaler wrap.
  - If `zero`=0: issue op 11.
  - If `zero`=1: issue nothing and set `complete`.
- **`complete`**
  - Stays high until `init_regs`=1 or reset.
  - While it is high, ticks are suppressed and the prescaler is frozen.
- **Repeat FSM** (one per button): states R_IDLE, R_DELAY, R_REPEAT.
  - R_IDLE → R_DELAY on a rising edge of the button; emit one pulse.
  - R_DELAY → R_REPEAT after REPEAT_DELAY cycles held; emit a pulse on entry.
  - In R_REPEAT, emit a pulse every REPEAT_PERIOD cycles.
  - Any state → R_IDLE when the button drops.
- Button pulses are gated off while `count_enabled`=1 or `complete`=1. The FSMs are forced to R_IDLE in that case.
- Arbitration, highest priority first: `init_regs` (blocks all updates that cycle) > tick > dec > inc.
  - If inc and dec pulse in the same cycle, both are dropped. Both FSMs keep running.
  - A lost lower-priority pulse is not queued.
- `upd_field` samples `min` in the same cycle as the winning pulse.

## Timing
- Manual: button rising edge sampled at edge n → `upd_valid`=1 during cycle n+1, for exactly one cycle.
- Repeat pulses follow at n+1+REPEAT_DELAY, then every REPEAT_PERIOD cycles.
- Run: first tick strobe occurs TICK_DIV cycles after the first edge sampling `count_enabled`=1 from a cleared prescaler.
- `complete` rises in the cycle a tick would have issued. It falls one cycle after `init_regs` is sampled.
- Pause and resume: the remaining count toward the next tick is preserved exactly.
- Reset asserted mid-operation: outputs go to their reset values immediately, independent of `clk`. No strobe is emitted on deassertion.

## Configuration
- `SCHED_AUTOREPEAT_EN` defined: repeat FSMs as described above.
- Not defined: exactly one pulse per rising edge. R_DELAY and R_REPEAT are not built, and REPEAT_DELAY and REPEAT_PERIOD are unused.

## Structure
- Shared package `sched_defs` holds:
  - op encodings OP_NONE, OP_INC, OP_DEC, OP_TICK;
  - field constants FLD_SEC, FLD_MIN;
  - repeat state encodings R_IDLE, R_DELAY, R_REPEAT.
- Sub-module `btn_repeat` contains edge detect, repeat FSM and repeat counter. It is instantiated twice, for inc and dec.
- The top level contains the prescaler, arbiter, `complete` register and output registers.

## Test plan
All scenarios use `TICK_DIV`=4, `REPEAT_DELAY`=6, `REPEAT_PERIOD`=3.
- Reset low mid-run with a tick pending → all outputs 0 at once. No strobe after reset releases.
- `min`=1, pulse `inc` for 1 cycle → exactly one strobe with op 01, field 1, one cycle later. Repeat with `dec` and `min`=0 → op 10, field 0.
- Hold `inc` 20 cycles (macro on) → strobes at offsets 1, 7, 10, 13, 16, 19. Macro off → a single strobe at offset 1.
- `count_enabled`=1, `zero`=0 for 12 cycles → op-11 strobes at cycles 4, 8, 12. Drop for 5 cycles after 2 counted cycles, then resume → next strobe 2 cycles after resume.
- `zero`=1 at a prescaler wrap → no strobe, `complete`=1 and held. `init_regs` pulse → `complete`=0 next cycle.
- `inc` and `dec` rising in the same cycle → no strobe. `inc` during `count_enabled`=1 → only op-11 strobes.

Source files
------------

// File: rtl/time_upd_sched_pkg.sv
// rtl/time_upd_sched_pkg.sv - shared encodings for the time update scheduler
// Holds update op codes, field selects and repeat FSM state encodings.
package sched_defs;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_TICK = 2'b11;

  localparam logic FLD_SEC = 1'b0;
  localparam logic FLD_MIN = 1'b1;

  localparam logic [1:0] R_IDLE   = 2'b00;
  localparam logic [1:0] R_DELAY  = 2'b01;
  localparam logic [1:0] R_REPEAT = 2'b10;

endpackage

// File: rtl/btn_repeat.sv
// rtl/btn_repeat.sv - button edge detect with optional auto-repeat (SCHED_AUTOREPEAT_EN)
// o_pulse is combinational; the top registers it into the update strobe.
module btn_repeat
  import sched_defs::*;
#(
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  input  logic i_gate,
  output logic o_pulse
);

  logic r_btn_q;
  logic w_rise;

  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("btn_repeat: repeat delay and period must be at least 1");
  end

  assign w_rise = i_btn & ~r_btn_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_btn_q <= 1'b0;
    else          r_btn_q <= i_btn;
  end

`ifdef SCHED_AUTOREPEAT_EN
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          w_delay_done;
  logic          w_period_done;

  assign w_delay_done  = (r_cnt == CW'(REPEAT_DELAY - 1));
  assign w_period_done = (r_cnt == CW'(REPEAT_PERIOD - 1));

  // Release or gating always returns to idle; a held button then needs a fresh edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
    end else if (i_gate || !i_btn) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (w_rise) r_state <= R_DELAY;
          r_cnt <= '0;
        end
        R_DELAY: begin
          if (w_delay_done) begin
            r_state <= R_REPEAT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        R_REPEAT: begin
          if (w_period_done) r_cnt <= '0;
          else               r_cnt <= r_cnt + 1'b1;
        end
        default: begin
          r_state <= R_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    o_pulse = 1'b0;
    if (!i_gate && i_btn) begin
      case (r_state)
        R_IDLE:   o_pulse = w_rise;
        R_DELAY:  o_pulse = w_delay_done;
        R_REPEAT: o_pulse = w_period_done;
        default:  o_pulse = 1'b0;
      endcase
    end
  end
`else
  assign o_pulse = ~i_gate & w_rise;
`endif

endmodule

// File: rtl/time_upd_sched.sv
// rtl/time_upd_sched.sv - shares the time datapath update port among tick, inc and dec
// Auto-repeat on held buttons is built only when SCHED_AUTOREPEAT_EN is defined.
module time_upd_sched
  import sched_defs::*;
#(
  parameter int TICK_DIV      = 100_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_init_regs,
  input  logic       i_count_enabled,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic       i_min,
  input  logic       i_zero,
  output logic       o_upd_valid,
  output logic [1:0] o_upd_op,
  output logic       o_upd_field,
  output logic       o_complete
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (TICK_DIV < 1) begin : g_bad_param
    $error("time_upd_sched: TICK_DIV must be at least 1");
  end

  logic [PW-1:0] r_presc;
  logic          r_complete;
  logic          w_run;
  logic          w_wrap;
  logic          w_gate;
  logic          w_inc_pulse;
  logic          w_dec_pulse;

  assign w_run  = i_count_enabled & ~r_complete;
  assign w_wrap = w_run & (r_presc == PW'(TICK_DIV - 1));
  assign w_gate = i_count_enabled | r_complete;

  btn_repeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_inc_rep (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_inc),
    .i_gate  (w_gate),
    .o_pulse (w_inc_pulse)
  );

  btn_repeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_dec_rep (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_dec),
    .i_gate  (w_gate),
    .o_pulse (w_dec_pulse)
  );

  // Prescaler holds while paused so a resume keeps the fractional second.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)         r_presc <= '0;
    else if (i_init_regs) r_presc <= '0;
    else if (w_run)       r_presc <= w_wrap ? '0 : r_presc + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)               r_complete <= 1'b0;
    else if (i_init_regs)       r_complete <= 1'b0;
    else if (w_wrap && i_zero)  r_complete <= 1'b1;
  end

  assign o_complete = r_complete;

  // Simultaneous inc and dec cancel each other rather than favouring one.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_upd_valid <= 1'b0;
      o_upd_op    <= OP_NONE;
      o_upd_field <= FLD_SEC;
    end else if (i_init_regs) begin
      o_upd_valid <= 1'b0;
      o_upd_op    <= OP_NONE;
      o_upd_field <= FLD_SEC;
    end else if (w_wrap && !i_zero) begin
      o_upd_valid <= 1'b1;
      o_upd_op    <= OP_TICK;
      o_upd_field <= FLD_SEC;
    end else if (w_dec_pulse && !w_inc_pulse) begin
      o_upd_valid <= 1'b1;
      o_upd_op    <= OP_DEC;
      o_upd_field <= i_min;
    end else if (w_inc_pulse && !w_dec_pulse) begin
      o_upd_valid <= 1'b1;
      o_upd_op    <= OP_INC;
      o_upd_field <= i_min;
    end else begin
      o_upd_valid <= 1'b0;
      o_upd_op    <= OP_NONE;
      o_upd_field <= FLD_SEC;
    end
  end

endmodule
